// File: rtl/pixel_fifo_if.sv
// Pixel FIFO bus: producer/consumer controls plus FIFO data and status.
//   master : drives flush, wr_en, wr_data, rd_fifo; observes data and status
//   slave  : the FIFO; drives rd_data, fifo_empty, full, almost_full, level,
//            done, ovf_err, udf_err
interface pixel_fifo_if #(
  parameter int unsigned DATA_W = 24,
  parameter int unsigned ADDR_W = 6
);
  logic              flush;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              rd_fifo;
  logic [DATA_W-1:0] rd_data;
  logic              fifo_empty;
  logic              full;
  logic              almost_full;
  logic [ADDR_W:0]   level;
  logic              done;
  logic              ovf_err;
  logic              udf_err;

  modport master (
    output flush, wr_en, wr_data, rd_fifo,
    input  rd_data, fifo_empty, full, almost_full, level, done, ovf_err, udf_err
  );

  modport slave (
    input  flush, wr_en, wr_data, rd_fifo,
    output rd_data, fifo_empty, full, almost_full, level, done, ovf_err, udf_err
  );
endinterface

// File: rtl/pixel_fifo_buf.sv
// Single-clock pixel FIFO feeding the VGA timing generator.
//   clk  : pixel clock, all logic on posedge
//   rst  : synchronous active-low reset
//   bus  : pixel_fifo_if.slave
//     flush       sync clear of contents, level, done, rd_data (error flags kept)
//     wr_en/data  push from pixel source
//     rd_fifo     pop from timing generator; rd_data valid the cycle after
//     fifo_empty/full/almost_full/level : combinational from registered level
//     done        sticky once level reaches PREFILL
//     ovf_err     sticky: push while full without a pop
//     udf_err     sticky: pop while empty
module pixel_fifo_buf #(
  parameter int unsigned DATA_W    = 24,
  parameter int unsigned ADDR_W    = 6,
  parameter int unsigned PREFILL   = 32,
  parameter int unsigned AFULL_LVL = 60
) (
  input  logic          clk,
  input  logic          rst,
  pixel_fifo_if.slave   bus
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned LVL_W = ADDR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [LVL_W-1:0]  level_q;
  logic [LVL_W-1:0]  level_nxt;
  logic [DATA_W-1:0] rd_data_q;
  logic              done_q;
  logic              ovf_q;
  logic              udf_q;

  logic empty_c;
  logic full_c;
  logic rd_acc;
  logic wr_acc;
  logic ovf_set;
  logic udf_set;

  // Status flags decoded from the registered level.
  assign empty_c = (level_q == '0);
  assign full_c  = (level_q == LVL_W'(DEPTH));

  // Accept rules use start-of-cycle state; a push into a full FIFO
  // rides on a same-cycle pop. No bypass when empty.
  assign rd_acc  = bus.rd_fifo & ~empty_c;
  assign wr_acc  = bus.wr_en & (~full_c | rd_acc);
  assign ovf_set = bus.wr_en & full_c & ~rd_acc;
  assign udf_set = bus.rd_fifo & empty_c;

  // Occupancy after this cycle's accepted operations.
  always_comb begin
    level_nxt = level_q;
    unique case ({wr_acc, rd_acc})
      2'b10:   level_nxt = level_q + LVL_W'(1);
      2'b01:   level_nxt = level_q - LVL_W'(1);
      default: level_nxt = level_q;
    endcase
  end

  // Storage write port; contents are not cleared, pointers define validity.
  always_ff @(posedge clk) begin
    if (rst && !bus.flush && wr_acc) begin
      mem[wr_ptr] <= bus.wr_data;
    end
  end

  // Pointers, level, read register and sticky flags.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level_q   <= '0;
      rd_data_q <= '0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
    end else if (bus.flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level_q   <= '0;
      rd_data_q <= '0;
      done_q    <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (rd_acc) begin
        rd_data_q <= mem[rd_ptr];
        rd_ptr    <= rd_ptr + ADDR_W'(1);
      end
      level_q <= level_nxt;
      // done stays set through draining so the raster keeps running.
      if (level_nxt >= LVL_W'(PREFILL)) begin
        done_q <= 1'b1;
      end
      if (ovf_set) begin
        ovf_q <= 1'b1;
      end
      if (udf_set) begin
        udf_q <= 1'b1;
      end
    end
  end

  assign bus.rd_data     = rd_data_q;
  assign bus.fifo_empty  = empty_c;
  assign bus.full        = full_c;
  assign bus.almost_full = (level_q >= LVL_W'(AFULL_LVL));
  assign bus.level       = level_q;
  assign bus.done        = done_q;
  assign bus.ovf_err     = ovf_q;
  assign bus.udf_err     = udf_q;

endmodule
